calc_hist: RTL

- Parametrised next-generation accumulator calculator for the FPGA board top level.
- Buttons are synchronised and edge-detected internally; one press gives exactly one operation.
- Operation sequencing is a three-state FSM. The ALU covers 8 operations with a signed-overflow flag.
- A D-deep history stack lets the user undo executed operations.

---
 rtl/calc_hist_pkg.sv | 21 ++
 rtl/calc_hist_btn_sync.sv | 42 ++++
 rtl/calc_hist.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/calc_hist_pkg.sv
// calc_hist_pkg: shared definitions for the history calculator.
//   state_t   - operation sequencer states (IDLE, EXEC, COMMIT)
//   OP_*      - 3-bit opcodes selected by {btnl, btnc, btnr}
package calc_hist_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EXEC   = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SLL = 3'd5;
  localparam logic [2:0] OP_SRA = 3'd6;
  localparam logic [2:0] OP_SLT = 3'd7;

endpackage

// File: rtl/calc_hist_btn_sync.sv
// calc_hist_btn_sync: two-flop synchroniser for one raw push button.
//   clk    - system clock
//   rst    - asynchronous active-high reset, clears all flops
//   i_btn  - raw, asynchronous button level
//   o_sig  - EDGE=0: synchronised level; EDGE=1: one-cycle pulse on the
//            synchronised rising edge (a held button yields one pulse)
module calc_hist_btn_sync #(
  parameter bit EDGE = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_sig
);

  logic r_s1;
  logic r_s2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= i_btn;
      r_s2 <= r_s1;
    end
  end

  generate
    if (EDGE) begin : g_edge
      logic r_s2_d;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) r_s2_d <= 1'b0;
        else     r_s2_d <= r_s2;
      end
      assign o_sig = r_s2 & ~r_s2_d;
    end else begin : g_level
      assign o_sig = r_s2;
    end
  endgenerate

endmodule

// File: rtl/calc_hist.sv
// calc_hist: accumulator calculator with an undo history stack.
//   clk       - system clock, all state on the rising edge
//   btnu      - asynchronous active-high reset
//   btnl/c/r  - raw opcode buttons (bit 2/1/0)
//   btnd      - raw execute button
//   undo      - raw undo button, restores the previous accumulator
//   sw        - signed operand 2
//   led       - current accumulator value
//   ovf       - signed overflow of the last committed ADD/SUB
//   hist_cnt  - number of valid history entries (0..D)
// An execute pulse in IDLE latches opcode and sw (p0), EXEC registers the
// ALU result (p1), COMMIT pushes the old accumulator and loads the result.
module calc_hist
  import calc_hist_pkg::*;
#(
  parameter  int W  = 16,
  parameter  int D  = 4,
  localparam int HW = $clog2(D + 1)
) (
  input  logic          clk,
  input  logic          btnu,
  input  logic          btnl,
  input  logic          btnc,
  input  logic          btnr,
  input  logic          btnd,
  input  logic          undo,
  input  logic [W-1:0]  sw,
  output logic [W-1:0]  led,
  output logic          ovf,
  output logic [HW-1:0] hist_cnt
);

  localparam int SHW = $clog2(W);
  localparam int PW  = (D > 1) ? $clog2(D) : 1;

  function automatic logic add_ovf(input logic signed [W-1:0] a,
                                   input logic signed [W-1:0] b,
                                   input logic signed [W-1:0] r);
    return (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
  endfunction

  function automatic logic sub_ovf(input logic signed [W-1:0] a,
                                   input logic signed [W-1:0] b,
                                   input logic signed [W-1:0] r);
    return (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
  endfunction

  logic [2:0] w_op;
  logic       w_exe;
  logic       w_undo;

  calc_hist_btn_sync #(.EDGE(1'b0)) u_sync_l (.clk(clk), .rst(btnu), .i_btn(btnl), .o_sig(w_op[2]));
  calc_hist_btn_sync #(.EDGE(1'b0)) u_sync_c (.clk(clk), .rst(btnu), .i_btn(btnc), .o_sig(w_op[1]));
  calc_hist_btn_sync #(.EDGE(1'b0)) u_sync_r (.clk(clk), .rst(btnu), .i_btn(btnr), .o_sig(w_op[0]));
  calc_hist_btn_sync #(.EDGE(1'b1)) u_sync_d (.clk(clk), .rst(btnu), .i_btn(btnd), .o_sig(w_exe));
  calc_hist_btn_sync #(.EDGE(1'b1)) u_sync_u (.clk(clk), .rst(btnu), .i_btn(undo), .o_sig(w_undo));

  state_t                r_state;
  logic signed [W-1:0]   r_acc;
  logic                  r_ovf;
  logic [HW-1:0]         r_cnt;
  logic [PW-1:0]         r_wp;     // next free slot of the circular history
  logic signed [W-1:0]   r_hist [D];

  logic [2:0]            r_op_p0;
  logic signed [W-1:0]   r_b_p0;
  logic signed [W-1:0]   r_res_p1;
  logic                  r_ovf_p1;

  logic [PW-1:0]         w_push_nxt;
  logic [PW-1:0]         w_pop_idx;
  logic [SHW-1:0]        w_sh;
  logic signed [W-1:0]   w_sum;
  logic signed [W-1:0]   w_diff;
  logic signed [W-1:0]   w_alu;
  logic                  w_alu_ovf;

  assign w_push_nxt = (r_wp == PW'(D - 1)) ? '0 : r_wp + PW'(1);
  assign w_pop_idx  = (r_wp == '0) ? PW'(D - 1) : r_wp - PW'(1);

  // ---- stage p0 -> p1: ALU on latched opcode/operand (acc is stable here)
  assign w_sh   = r_b_p0[SHW-1:0];
  assign w_sum  = r_acc + r_b_p0;
  assign w_diff = r_acc - r_b_p0;

  always_comb begin
    w_alu     = '0;
    w_alu_ovf = 1'b0;
    case (r_op_p0)
      OP_ADD: begin
        w_alu     = w_sum;
        w_alu_ovf = add_ovf(r_acc, r_b_p0, w_sum);
      end
      OP_SUB: begin
        w_alu     = w_diff;
        w_alu_ovf = sub_ovf(r_acc, r_b_p0, w_diff);
      end
      OP_AND:  w_alu = r_acc & r_b_p0;
      OP_OR:   w_alu = r_acc | r_b_p0;
      OP_XOR:  w_alu = r_acc ^ r_b_p0;
      OP_SLL:  w_alu = r_acc << w_sh;
      OP_SRA:  w_alu = r_acc >>> w_sh;
      default: w_alu = (r_acc < r_b_p0) ? W'(1) : '0;
    endcase
  end

  // ---- datapath registers (no reset: only read once the FSM makes them valid)
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && w_exe) begin
      r_op_p0 <= w_op;
      r_b_p0  <= sw;
    end
    if (r_state == S_EXEC) begin
      r_res_p1 <= w_alu;
      r_ovf_p1 <= w_alu_ovf;
    end
    if (r_state == S_COMMIT) begin
      r_hist[r_wp] <= r_acc;
    end
  end

  // ---- sequencer, accumulator and history bookkeeping
  always_ff @(posedge clk or posedge btnu) begin
    if (btnu) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_ovf   <= 1'b0;
      r_cnt   <= '0;
      r_wp    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // execute has priority; a simultaneous undo pulse is dropped
          if (w_exe) begin
            r_state <= S_EXEC;
          end else if (w_undo && r_cnt != '0) begin
            r_acc <= r_hist[w_pop_idx];
            r_wp  <= w_pop_idx;
            r_cnt <= r_cnt - HW'(1);
            r_ovf <= 1'b0;
          end
        end
        S_EXEC: begin
          r_state <= S_COMMIT;
        end
        S_COMMIT: begin
          r_state <= S_IDLE;
          r_acc   <= r_res_p1;
          r_ovf   <= r_ovf_p1;
          r_wp    <= w_push_nxt;
          // a full stack overwrites its oldest entry and stays full
          if (r_cnt != HW'(D)) r_cnt <= r_cnt + HW'(1);
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign led      = r_acc;
  assign ovf      = r_ovf;
  assign hist_cnt = r_cnt;

endmodule
